// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Holds the mult/div operation codes used by the decoder and the hazard
// logic, the sequencer state encoding, the step-mode selector and two small
// operation-decode helpers.
package mdu_sequencer_pkg;

    // Operation codes on the op port
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFix  = 2'b10,
        StDone = 2'b11
    } md_state_e;

    typedef enum logic {
        StepMul = 1'b0,
        StepDiv = 1'b1
    } md_step_mode_e;

    // op[1] selects divide, op[0] selects unsigned.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the shared multiply/divide datapath.
// Purely combinational.
//
// Ports:
//   mode_i     StepMul: shift-add multiply, StepDiv: restoring divide
//   acc_i      current accumulator (2*WIDTH+1 bits)
//                mul: [2W:W] running upper product, [W-1:0] multiplier bits
//                div: [2W:W] partial remainder,     [W-1:0] dividend/quotient
//   operand_i  multiplicand (mul) or divisor (div), both as magnitudes
//   acc_o      accumulator after this iteration
module mdu_step
    import mdu_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  md_step_mode_e      mode_i,
    input  logic [2*WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    output logic [2*WIDTH:0]   acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        // Multiply: upper half never exceeds WIDTH bits before the add, so a
        // WIDTH+1 bit sum cannot overflow.
        sum = acc_i[2*WIDTH:WIDTH] + {1'b0, operand_i};

        // Divide: remainder is always below the divisor, so dropping its top
        // bit on the left shift loses nothing.
        shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, operand_i};

        acc_o = acc_i;
        if (mode_i == StepMul) begin
            if (acc_i[0]) begin
                acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[2*WIDTH:1]};
            end
        end else begin
            // trial[WIDTH+1] is the borrow: set means the divisor did not fit.
            if (!trial[WIDTH+1]) begin
                acc_o = {trial[WIDTH:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {shifted, acc_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
// Runs MULT/MULTU/DIV/DIVU over WIDTH cycles on the shared mdu_step datapath
// and stalls the pipeline while busy.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           EX holds a mult/div instruction (level)
//   op              MD_MULT / MD_MULTU / MD_DIV / MD_DIVU
//   srca, srcb      rs / rt operands
//   cancel          EX flush; aborts a running operation
//   wr_hi, wr_lo    MTHI / MTLO strobes, data on wdata
//   stall           combinational pipeline hold
//   done            one-cycle pulse once HI/LO hold the new result
//   hi, lo          HI/LO registers
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             cancel,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam int unsigned AccW = 2 * WIDTH + 1;

    md_state_e         state_q, state_d;
    logic              div_q, div_d;          // only divide-vs-multiply is needed after latch
    logic [AccW-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic              neg_res_q, neg_res_d;  // operand signs differ
    logic              neg_rem_q, neg_rem_d;  // dividend negative
    logic              div0_q, div0_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;

    // Operand preparation for the IDLE latch
    logic              a_neg, b_neg;
    logic [WIDTH-1:0]  a_mag, b_mag;

    assign a_neg = op_is_signed(op) & srca[WIDTH-1];
    assign b_neg = op_is_signed(op) & srcb[WIDTH-1];
    assign a_mag = a_neg ? -srca : srca;
    assign b_mag = b_neg ? -srcb : srcb;

    // Shared datapath
    logic [AccW-1:0]   step_acc;

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode_i    (div_q ? StepDiv : StepMul),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (step_acc)
    );

    // Sign fixup of the finished magnitude result
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo, quo_fix, rem, rem_fix;

    always_comb begin
        prod     = acc_q[2*WIDTH-1:0];
        prod_fix = neg_res_q ? -prod : prod;
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
        // Divide by zero: quotient forced to all ones. The remainder path
        // already reproduces srca because the dividend bits shift in unchanged.
        quo_fix  = div0_q ? {WIDTH{1'b1}} : (neg_res_q ? -quo : quo);
        rem_fix  = neg_rem_q ? -rem : rem;
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !cancel) begin
                    div_d     = op_is_div(op);
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    div0_d    = (srcb == '0);
                    count_d   = '0;
                    if (op_is_div(op)) begin
                        acc_d  = {{(WIDTH + 1){1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        acc_d  = {{(WIDTH + 1){1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
                    state_d = StCalc;
                end
            end
            StCalc: begin
                acc_d   = step_acc;
                count_d = count_q + 1'b1;
                if (count_q == CntW'(WIDTH - 1)) begin
                    count_d = '0;
                    state_d = StFix;
                end
                if (cancel) begin
                    count_d = '0;
                    state_d = StIdle;
                end
            end
            StFix: begin
                if (cancel) begin
                    state_d = StIdle;
                end else begin
                    if (div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // MTHI/MTLO; in DONE this overrides the result just written.
        if (state_q == StIdle || state_q == StDone) begin
            if (wr_hi) hi_d = wdata;
            if (wr_lo) lo_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            div_q     <= 1'b0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign stall = (state_q == StIdle && start && !cancel) ||
                   (state_q == StCalc) || (state_q == StFix);
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed corner cases plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] srca, srcb;
    logic         cancel;
    logic         wr_hi, wr_lo;
    logic [W-1:0] wdata;
    logic         stall, done;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_hi, exp_lo;

    mdu_sequencer #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .srca   (srca),
        .srcb   (srcb),
        .cancel (cancel),
        .wr_hi  (wr_hi),
        .wr_lo  (wr_lo),
        .wdata  (wdata),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference result straight from the arithmetic definition.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint          p, q, r;
        longint unsigned pu;
        case (o)
            MD_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {h, l} = p;
            end
            MD_MULTU: begin
                pu = {32'd0, a} * {32'd0, b};
                {h, l} = pu;
            end
            MD_DIV: begin
                if (b == 0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    // 64-bit signed math; 0x80000000 / -1 wraps to 0x80000000
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    l = q[31:0];
                    h = r[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    // Called just after a rising edge; returns just after the edge ending DONE.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit keep_start, input bit mtlo_in_done, input logic [31:0] mt_val);
        logic [31:0] eh, el;
        model(o, a, b, eh, el);
        op = o; srca = a; srcb = b; start = 1'b1; cancel = 1'b0;
        for (int c = 0; c <= 34; c++) begin
            if (c == 34 && mtlo_in_done) begin
                wr_lo = 1'b1;
                wdata = mt_val;
            end
            @(negedge clk);
            check_eq($sformatf("op%0d stall/done cycle %0d", o, c), {stall, done},
                     {c <= 33, c == 34});
            if (c == 34) begin
                check_eq($sformatf("op%0d %h,%h hi", o, a, b), hi, eh);
                check_eq($sformatf("op%0d %h,%h lo", o, a, b), lo, el);
            end
            @(posedge clk);
            #1;
        end
        wr_lo = 1'b0;
        if (mtlo_in_done) el = mt_val;
        exp_hi = eh;
        exp_lo = el;
        if (!keep_start) start = 1'b0;
    endtask

    task automatic watch_no_done(input string tag, input int n);
        bit seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            seen |= done;
        end
        check_eq(tag, seen, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_hilo(input string tag);
        check_eq({tag, " hi"}, hi, exp_hi);
        check_eq({tag, " lo"}, lo, exp_lo);
    endtask

    task automatic run_cancel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              input int cancel_cycle);
        op = o; srca = a; srcb = b; start = 1'b1; cancel = 1'b0;
        for (int c = 0; c <= cancel_cycle; c++) begin
            if (c == cancel_cycle) cancel = 1'b1;
            @(negedge clk);
            check_eq($sformatf("cancel@%0d stall cycle %0d", cancel_cycle, c), stall, 1'b1);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
        check_eq("stall after cancel", stall, 1'b0);
        watch_no_done("no done after cancel", 40);
        check_hilo("hilo after cancel");
    endtask

    task automatic mt_write(input bit do_hi, input bit do_lo, input logic [31:0] val);
        wr_hi = do_hi; wr_lo = do_lo; wdata = val;
        @(posedge clk);
        #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        if (do_hi) exp_hi = val;
        if (do_lo) exp_lo = val;
        check_hilo("mthi/mtlo idle");
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; op = MD_MULT; srca = '0; srcb = '0;
        cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        exp_hi = '0; exp_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset stall/done", {stall, done}, 2'b00);
        check_hilo("reset");
        @(posedge clk);
        #1;

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
        check_eq("multu hi value", exp_hi, hi);
        check_eq("multu hi const", hi, 32'hFFFF_FFFE);
        check_eq("multu lo const", lo, 32'h0000_0001);
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, '0);
        check_eq("mult -3*5 lo", lo, 32'hFFFF_FFF1);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0);
        check_eq("div -7/2 lo", lo, 32'hFFFF_FFFD);
        check_eq("div -7/2 hi", hi, 32'hFFFF_FFFF);
        run_op(MD_DIVU, 32'd10, 32'd0, 1'b0, 1'b0, '0);
        check_eq("divu 10/0 lo", lo, 32'hFFFF_FFFF);
        check_eq("divu 10/0 hi", hi, 32'h0000_000A);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, '0);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
        check_eq("div min/-1 lo", lo, 32'h8000_0000);
        check_eq("div min/-1 hi", hi, 32'h0000_0000);

        run_cancel(MD_DIVU, 32'd100, 32'd7, 10);
        run_cancel(MD_MULT, 32'd123, 32'd456, 33);

        // start together with cancel in IDLE is not accepted
        op = MD_DIVU; srca = 32'd100; srcb = 32'd7; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        check_eq("start+cancel stall", stall, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        check_eq("start+cancel stays idle", stall, 1'b0);
        watch_no_done("start+cancel no done", 40);
        check_hilo("start+cancel");

        // MTLO in DONE overrides LO, start held through DONE, then back-to-back
        run_op(MD_MULT, 32'h0001_2345, 32'h0006_7890, 1'b1, 1'b1, 32'h0000_1234);
        check_hilo("mtlo in done");
        run_op(MD_MULT, 32'hFFFF_0000, 32'h0000_7FFF, 1'b0, 1'b0, '0);
        check_hilo("back-to-back");

        mt_write(1'b1, 1'b0, 32'hCAFE_F00D);
        mt_write(1'b0, 1'b1, 32'h0BAD_BEEF);

        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'b0, 1'b0, '0);
            if ($urandom_range(0, 3) == 0) begin
                mt_write($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        // Reset in the middle of a MULT
        op = MD_MULT; srca = 32'h1234_5678; srcb = 32'h9ABC_DEF0; start = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            if (c == 20) rst = 1'b1;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        start = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        check_eq("stall after reset", stall, 1'b0);
        check_hilo("after mid-op reset");
        watch_no_done("no done after reset", 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative multiply/divide sequencer for the EX stage of the five-stage pipeline. It owns the HI/LO register pair and runs MULT/MULTU/DIV/DIVU over WIDTH cycles using one shared shift/add/subtract datapath. It stalls the pipeline while busy. Unlike the single-cycle ALU path selected by the ALU decoder, this block is a multi-cycle resource with a start/stall/done handshake to the hazard logic.

## Interface
- WIDTH, 32, operand and HI/LO width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  EX holds a mult/div instruction; level, held while stalled
- op  in  2  operation, codes from shared package
- srca  in  WIDTH  dividend / multiplicand (rs)
- srcb  in  WIDTH  divisor / multiplier (rt)
- cancel  in  1  flush of EX (exception/branch); aborts operation
- wr_hi  in  1  MTHI write strobe
- wr_lo  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- stall  out  1  hold IF/ID/EX; combinational
- done  out  1  one-cycle pulse, HI/LO hold the new result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 and cancel=0 → latch op, operand magnitudes (signed ops) or raw operands (unsigned ops), sign flags and count=0; go to CALC. With cancel=1, start is not accepted.
- CALC: one radix-2 step per cycle. Multiply uses shift-add into a 2·WIDTH accumulator. Divide uses restoring shift-subtract, with the remainder held as WIDTH+1 bits. After the step with count=WIDTH-1, go to FIX.
- FIX: apply signs. Product is negated if the operand signs differ. Quotient is negated if the signs differ; remainder takes the dividend's sign. Write HI/LO at the end of FIX: mult HI=upper, LO=lower; div LO=quotient, HI=remainder. Go to DONE.
- DONE: done=1 for exactly this cycle, stall=0, start is ignored. Always go to IDLE next.
- Divide by zero, both DIV and DIVU: LO=all ones, HI=srca, sign fixup bypassed.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- cancel in CALC or FIX: return to IDLE next cycle. HI/LO unchanged, no done.
- MTHI/MTLO: accepted in IDLE and DONE. In DONE they override the just-written value. Ignored in CALC and FIX; the pipeline is stalled there, so none arrive.
- All arithmetic is modulo 2^WIDTH per half. No overflow flags.

## Timing
- Reset: state=IDLE, count=0, hi=0, lo=0, done=0. Stall is then combinational on start.
- stall = (IDLE & start & ~cancel) | CALC | FIX.
- Start sampled at edge 0 → CALC for edges 1..WIDTH → FIX at edge WIDTH+1. The HI/LO write occurs at that edge.
- done is high in the cycle after edge WIDTH+1 (cycle WIDTH+2 counting the start cycle as 0). Stall is low in that cycle, so the instruction leaves EX.
- Latency: WIDTH+2 cycles from start to done. A back-to-back mult/div is accepted in the IDLE cycle following DONE.
- rst mid-operation overrides everything: IDLE, HI/LO cleared.
- cancel and rst take effect at the same edge they are sampled.

## Structure
- Shared package (alongside the ALU control codes) holds:
  - MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11
  - state encoding for IDLE/CALC/FIX/DONE
- One sub-module is natural: mdu_step. It is the combinational single-iteration multiply/divide step, taking accumulator, operand and mode and producing the next accumulator. The FSM, counter, sign fixup and HI/LO stay in mdu_sequencer.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → stall high cycles 0..33; done at cycle 34; HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (−3) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 10/0 → LO=0xFFFFFFFF, HI=0x0000000A; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Start DIVU 100/7, cancel at cycle 10 → stall low at cycle 11, no done, HI/LO keep the prior values. Start with cancel both high in IDLE → not accepted, stall=0.
- MTLO 0x1234 in the DONE cycle of a MULT → LO=0x1234, HI=product upper. With start held high through DONE → no re-trigger; a second MULT immediately after → accepted, done 34 cycles later.
- rst at cycle 20 of a MULT → hi=lo=0, done never pulses, stall=0 next cycle.
